// File: rtl/dac_thrsh_pulse_gen.sv
// dac_thrsh_pulse_gen: threshold-triggered TTL pulse generator with refractory lockout and event counters
module dac_thrsh_pulse_gen #(
    parameter logic [31:0] ms_clk1_a = 32'd100
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic        thrsh_in,
    input  logic        enable,
    input  logic [15:0] pulse_width,
    input  logic [15:0] refractory,
    input  logic        count_clear,
    output logic        ttl_out,
    output logic        busy,
    output logic [15:0] event_count,
    output logic [15:0] dropped_count
);
    typedef enum logic [1:0] {IDLE, PULSE, REFRACT} state_t;

    state_t      state_q, state_d;
    logic        thrsh_prev_q, thrsh_prev_d;
    logic        ttl_out_q, ttl_out_d;
    logic        busy_q, busy_d;
    logic [15:0] width_q, width_d;
    logic [15:0] refr_q, refr_d;
    logic [15:0] event_count_q, event_count_d;
    logic [15:0] dropped_count_q, dropped_count_d;
    logic        strobe, rise, accept, drop;

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q         <= IDLE;
            thrsh_prev_q    <= 1'b1;
            ttl_out_q       <= 1'b0;
            busy_q          <= 1'b0;
            width_q         <= 16'd0;
            refr_q          <= 16'd0;
            event_count_q   <= 16'd0;
            dropped_count_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            thrsh_prev_q    <= thrsh_prev_d;
            ttl_out_q       <= ttl_out_d;
            busy_q          <= busy_d;
            width_q         <= width_d;
            refr_q          <= refr_d;
            event_count_q   <= event_count_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    // width_q holds the PULSE cycles remaining after the current one
    always_comb begin
        strobe       = (main_state == ms_clk1_a) && (channel == 6'd0);
        rise         = strobe && thrsh_in && !thrsh_prev_q;
        thrsh_prev_d = strobe ? thrsh_in : thrsh_prev_q;
        state_d      = state_q;
        width_d      = width_q;
        refr_d       = refr_q;
        unique case (state_q)
            IDLE: if (rise) begin
                state_d = PULSE;
                width_d = (pulse_width == 16'd0) ? 16'd0 : pulse_width - 16'd1;
                refr_d  = refractory;
            end
            PULSE: if (width_q == 16'd0) state_d = (refr_q != 16'd0) ? REFRACT : IDLE;
                   else width_d = width_q - 16'd1;
            REFRACT: if (strobe) begin
                refr_d = refr_q - 16'd1;
                if (refr_q == 16'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_comb begin
        accept          = rise && enable && (state_q == IDLE);
        drop            = rise && enable && (state_q != IDLE);
        ttl_out_d       = (state_d == PULSE);
        busy_d          = (state_d != IDLE);
        event_count_d   = count_clear ? 16'd0 :
                          (accept && event_count_q != 16'hFFFF) ? event_count_q + 16'd1 : event_count_q;
        dropped_count_d = count_clear ? 16'd0 :
                          (drop && dropped_count_q != 16'hFFFF) ? dropped_count_q + 16'd1 : dropped_count_q;
    end

    assign ttl_out       = ttl_out_q;
    assign busy          = busy_q;
    assign event_count   = event_count_q;
    assign dropped_count = dropped_count_q;
endmodule

// File: tb/tb_dac_thrsh_pulse_gen.sv
// tb_dac_thrsh_pulse_gen: directed self-checking bench for dac_thrsh_pulse_gen
module tb_dac_thrsh_pulse_gen;
    localparam logic [31:0] MS = 32'd100;

    logic        dataclk = 1'b0;
    logic        reset, thrsh_in, enable, count_clear, ttl_out, busy;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] pulse_width, refractory, event_count, dropped_count;
    int          checks = 0;
    int          errors = 0;

    dac_thrsh_pulse_gen #(.ms_clk1_a(MS)) dut (
        .dataclk(dataclk), .reset(reset), .main_state(main_state), .channel(channel),
        .thrsh_in(thrsh_in), .enable(enable), .pulse_width(pulse_width), .refractory(refractory),
        .count_clear(count_clear), .ttl_out(ttl_out), .busy(busy),
        .event_count(event_count), .dropped_count(dropped_count)
    );

    always #5 dataclk = ~dataclk;

    task automatic tick();
        @(posedge dataclk);
        #1;
    endtask

    task automatic strobe(input logic th);
        main_state = MS;
        channel    = 6'd0;
        thrsh_in   = th;
        tick();
        main_state = 32'd0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; main_state = 32'd0; channel = 6'd0; thrsh_in = 1'b0;
        pulse_width = 16'd0; refractory = 16'd0; count_clear = 1'b0;
        tick(); tick();
        check("rst_ttl", {15'd0, ttl_out}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_ev", event_count, 16'd0);
        check("rst_dr", dropped_count, 16'd0);
        reset = 1'b0;

        enable = 1'b1; pulse_width = 16'd5; refractory = 16'd0;
        strobe(1'b0);
        main_state = MS; channel = 6'd1; thrsh_in = 1'b1;
        tick();
        check("t1_nonstrobe", {15'd0, ttl_out}, 16'd0);
        main_state = 32'd0; channel = 6'd0;
        strobe(1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t1_hi", {15'd0, ttl_out}, 16'd1);
            tick();
        end
        check("t1_lo", {15'd0, ttl_out}, 16'd0);
        check("t1_busy", {15'd0, busy}, 16'd0);
        check("t1_ev", event_count, 16'd1);

        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        check("t2_clr_ev", event_count, 16'd0);
        pulse_width = 16'd3; refractory = 16'd2;
        strobe(1'b0);
        strobe(1'b1);
        check("t2_p1", {15'd0, ttl_out}, 16'd1);
        pulse_width = 16'd9;
        strobe(1'b0);
        check("t2_p2", {15'd0, ttl_out}, 16'd1);
        tick();
        check("t2_p3", {15'd0, ttl_out}, 16'd1);
        tick();
        check("t2_end_ttl", {15'd0, ttl_out}, 16'd0);
        check("t2_refr_busy", {15'd0, busy}, 16'd1);
        strobe(1'b1);
        check("t2_dropped", dropped_count, 16'd1);
        check("t2_drop_busy", {15'd0, busy}, 16'd1);
        check("t2_drop_ttl", {15'd0, ttl_out}, 16'd0);
        strobe(1'b0);
        check("t2_refr_done", {15'd0, busy}, 16'd0);
        strobe(1'b1);
        check("t2_accept_ttl", {15'd0, ttl_out}, 16'd1);
        check("t2_ev", event_count, 16'd2);
        check("t2_dr", dropped_count, 16'd1);
        for (int i = 0; i < 8; i++) tick();
        check("t2_latched_hi", {15'd0, ttl_out}, 16'd1);
        tick();
        check("t2_latched_lo", {15'd0, ttl_out}, 16'd0);
        enable = 1'b0;
        tick();
        check("t2_dis_busy", {15'd0, busy}, 16'd0);
        enable = 1'b1;

        thrsh_in = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; pulse_width = 16'd0; refractory = 16'd0;
        strobe(1'b1);
        check("t3_held1", {15'd0, ttl_out}, 16'd0);
        strobe(1'b1);
        check("t3_held2", {15'd0, ttl_out}, 16'd0);
        check("t3_ev0", event_count, 16'd0);
        strobe(1'b0);
        strobe(1'b1);
        check("t3_pw0_hi", {15'd0, ttl_out}, 16'd1);
        tick();
        check("t3_pw0_lo", {15'd0, ttl_out}, 16'd0);
        check("t3_busy", {15'd0, busy}, 16'd0);
        check("t3_ev", event_count, 16'd1);

        pulse_width = 16'd10;
        strobe(1'b0);
        strobe(1'b1);
        check("t4_c1", {15'd0, ttl_out}, 16'd1);
        tick();
        check("t4_c2", {15'd0, ttl_out}, 16'd1);
        enable = 1'b0;
        tick();
        check("t4_dis_ttl", {15'd0, ttl_out}, 16'd0);
        check("t4_dis_busy", {15'd0, busy}, 16'd0);
        enable = 1'b1;
        tick();
        check("t4_idle_ttl", {15'd0, ttl_out}, 16'd0);
        check("t4_idle_busy", {15'd0, busy}, 16'd0);
        check("t4_ev", event_count, 16'd2);
        check("t4_dr", dropped_count, 16'd0);

        pulse_width = 16'd0;
        force dut.event_count_d = 16'hFFFE;
        tick();
        release dut.event_count_d;
        check("t5_preset", event_count, 16'hFFFE);
        strobe(1'b0);
        strobe(1'b1);
        check("t5_max", event_count, 16'hFFFF);
        strobe(1'b0);
        strobe(1'b1);
        check("t5_sat", event_count, 16'hFFFF);
        check("t5_sat_ttl", {15'd0, ttl_out}, 16'd1);
        strobe(1'b0);
        count_clear = 1'b1;
        strobe(1'b1);
        count_clear = 1'b0;
        check("t5_clr_ev", event_count, 16'd0);
        check("t5_clr_ttl", {15'd0, ttl_out}, 16'd1);

        pulse_width = 16'd4; refractory = 16'd3;
        tick();
        strobe(1'b0);
        strobe(1'b1);
        check("t6_pulse", {15'd0, ttl_out}, 16'd1);
        check("t6_ev1", event_count, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rstp_ttl", {15'd0, ttl_out}, 16'd0);
        check("t6_rstp_ev", event_count, 16'd0);
        strobe(1'b0);
        strobe(1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t6_refr_busy", {15'd0, busy}, 16'd1);
        check("t6_refr_ttl", {15'd0, ttl_out}, 16'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_ttl", {15'd0, ttl_out}, 16'd0);
        check("t6_rst_busy", {15'd0, busy}, 16'd0);
        check("t6_rst_ev", event_count, 16'd0);
        check("t6_rst_dr", dropped_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
